// File: rtl/sram_fifo_subsystem_if.sv
// FIFO-side bus of the SRAM-backed FIFO: strobes, data, flags and
// observation of the SRAM control lines.
interface sram_fifo_subsystem_if #(
    parameter int DW = 8,
    parameter int AW = 11
);
    logic [DW-1:0] in_data;
    logic          fifowr;
    logic          fiford;
    logic [DW-1:0] out_data;
    logic          nfull;
    logic          nempty;
    logic [AW-1:0] address;
    logic          rd;
    logic          wr;

    modport master (
        output in_data, fifowr, fiford,
        input  out_data, nfull, nempty, address, rd, wr
    );

    modport slave (
        input  in_data, fifowr, fiford,
        output out_data, nfull, nempty, address, rd, wr
    );
endinterface

// File: rtl/sram_fifo_subsystem.sv
// FIFO controller driving a 2^AW x DW SRAM over a shared tristate bus.
// Strobes are active-low, async to clk, and edge-detected after a register.
module sram_fifo_sram #(
    parameter int DW = 8,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          i_cs_n,
    input  logic          i_oe_n,
    input  logic          i_srw_n,
    input  logic [AW-1:0] i_addr,
    inout  wire  [DW-1:0] io_data
);
    logic [DW-1:0] r_mem [2**AW];

    // write commits at the edge that ends the one-cycle write pulse
    always_ff @(posedge clk) begin
        if (!i_cs_n && !i_srw_n) r_mem[i_addr] <= io_data;
    end

    assign io_data = (!i_cs_n && !i_oe_n && i_srw_n) ? r_mem[i_addr] : 'z;
endmodule

module sram_fifo_subsystem #(
    parameter int FIFO_SIZE = 8,
    parameter int DW        = 8,
    parameter int AW        = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_fifo_subsystem_if.slave  fifo
);
    localparam logic [AW:0]   L_SIZE = (AW+1)'(FIFO_SIZE);
    localparam logic [AW-1:0] L_LAST = AW'(FIFO_SIZE - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t        r_state, w_next;
    logic          r_wr_s, r_wr_p, r_rd_s, r_rd_p;
    logic          r_wpend, r_rpend, w_wpend, w_rpend;
    logic          w_wreq, w_rreq;
    logic [AW-1:0] r_wptr, r_rptr, r_addr, w_addr;
    logic [AW:0]   r_count;
    logic [DW-1:0] r_out;
    logic          r_nfull, r_nempty;
    logic          w_wr, w_rd;
    wire  [DW-1:0] w_bus;

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == L_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_wreq = r_wpend | (~r_wr_s & r_wr_p);
    assign w_rreq = r_rpend | (~r_rd_s & r_rd_p);

    // a pending write always goes first; the read waits for the next IDLE
    always_comb begin
        w_next  = r_state;
        w_addr  = r_addr;
        w_wpend = w_wreq;
        w_rpend = w_rreq;
        case (r_state)
            IDLE: begin
                if (w_wreq) begin
                    w_wpend = 1'b0;
                    if (r_count != L_SIZE) begin
                        w_next = WRITE;
                        w_addr = r_wptr;
                    end
                end else if (w_rreq) begin
                    w_rpend = 1'b0;
                    if (r_count != '0) begin
                        w_next = READ;
                        w_addr = r_rptr;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_wr_s   <= 1'b1;
            r_wr_p   <= 1'b1;
            r_rd_s   <= 1'b1;
            r_rd_p   <= 1'b1;
            r_wpend  <= 1'b0;
            r_rpend  <= 1'b0;
            r_addr   <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_out    <= '0;
            r_nfull  <= 1'b1;
            r_nempty <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_wr_s   <= fifo.fifowr;
            r_wr_p   <= r_wr_s;
            r_rd_s   <= fifo.fiford;
            r_rd_p   <= r_rd_s;
            r_wpend  <= w_wpend;
            r_rpend  <= w_rpend;
            r_addr   <= w_addr;
            r_nfull  <= (r_count != L_SIZE);
            r_nempty <= (r_count != '0);
            if (r_state == WRITE) begin
                r_wptr  <= f_inc(r_wptr);
                r_count <= r_count + 1'b1;
            end
            if (r_state == READ) begin
                r_out   <= w_bus;
                r_rptr  <= f_inc(r_rptr);
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign w_wr  = (r_state != WRITE);
    assign w_rd  = (r_state != READ);
    assign w_bus = (r_state == WRITE) ? fifo.in_data : 'z;

    sram_fifo_sram #(.DW(DW), .AW(AW)) u_sram (
        .clk     (clk),
        .i_cs_n  (1'b0),
        .i_oe_n  (w_rd),
        .i_srw_n (w_wr),
        .i_addr  (r_addr),
        .io_data (w_bus)
    );

    assign fifo.out_data = r_out;
    assign fifo.nfull    = r_nfull;
    assign fifo.nempty   = r_nempty;
    assign fifo.address  = r_addr;
    assign fifo.rd       = w_rd;
    assign fifo.wr       = w_wr;
endmodule

// File: tb/tb_sram_fifo_subsystem.sv
// Bench for sram_fifo_subsystem: random data against a queue model of
// the FIFO, with pulse counts, addresses, flags and reset behaviour.
module tb_sram_fifo_subsystem;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] q[$];
    logic [7:0] last_out = '0;
    int         wcnt = 0;
    int         rcnt = 0;

    sram_fifo_subsystem_if #(.DW(8), .AW(11)) f ();

    sram_fifo_subsystem #(.FIFO_SIZE(N), .DW(8), .AW(11)) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_nfull"}, 32'(f.nfull), 32'(q.size() != N));
        chk({tag, "_nempty"}, 32'(f.nempty), 32'(q.size() != 0));
        chk({tag, "_out"}, 32'(f.out_data), 32'(last_out));
    endtask

    task automatic model_reset();
        q.delete();
        last_out = '0;
        wcnt = 0;
        rcnt = 0;
    endtask

    task automatic do_write(input logic [7:0] d);
        bit         acc;
        int         wl;
        logic [10:0] a;
        acc = (q.size() < N);
        wl = 0;
        a = '0;
        @(negedge clk);
        f.in_data = d;
        f.fifowr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (f.wr === 1'b0) begin wl++; a = f.address; end
        end
        f.fifowr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (f.wr === 1'b0) wl++;
        end
        chk("wr_pulses", 32'(wl), acc ? 32'd1 : 32'd0);
        if (acc) begin
            chk("wr_addr", 32'(a), 32'(wcnt % N));
            q.push_back(d);
            wcnt++;
        end
        chk_flags("wr");
    endtask

    task automatic do_read();
        bit         acc;
        int         rl;
        logic [10:0] a;
        logic [7:0] early;
        acc = (q.size() > 0);
        rl = 0;
        a = '0;
        @(negedge clk);
        f.fiford = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (f.rd === 1'b0) begin rl++; a = f.address; end
        end
        early = f.out_data;
        f.fiford = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (f.rd === 1'b0) rl++;
        end
        chk("rd_pulses", 32'(rl), acc ? 32'd1 : 32'd0);
        if (acc) begin
            chk("rd_addr", 32'(a), 32'(rcnt % N));
            last_out = q.pop_front();
            rcnt++;
            chk("rd_latency", 32'(early), 32'(last_out));
        end
        chk_flags("rd");
    endtask

    task automatic do_both(input logic [7:0] d);
        @(negedge clk);
        f.in_data = d;
        f.fifowr = 1'b0;
        f.fiford = 1'b0;
        repeat (5) @(negedge clk);
        f.fifowr = 1'b1;
        f.fiford = 1'b1;
        repeat (3) @(negedge clk);
        if (q.size() < N) begin q.push_back(d); wcnt++; end
        if (q.size() > 0) begin last_out = q.pop_front(); rcnt++; end
        chk_flags("both");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        chk_flags("rst");
        chk("rst_addr", 32'(f.address), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit found;
        f.in_data = '0;
        f.fifowr = 1'b1;
        f.fiford = 1'b1;
        repeat (3) @(negedge clk);
        chk_flags("init");
        chk("init_rd", 32'(f.rd), 32'd1);
        chk("init_wr", 32'(f.wr), 32'd1);
        chk("init_addr", 32'(f.address), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < N + 2; i++) do_write(8'($urandom));
        for (int i = 0; i < N; i++) do_read();
        for (int i = 0; i < 2; i++) do_read();
        for (int i = 0; i < 2 * N; i++) begin
            do_write(8'($urandom));
            do_read();
        end
        do_both(8'($urandom));
        do_write(8'($urandom));
        do_both(8'($urandom));
        do_read();

        for (int i = 0; i < 3; i++) do_write(8'($urandom));
        do_reset();
        do_read();
        do_write(8'hA5);
        do_read();
        chk("a5_back", 32'(f.out_data), 32'h0000_00A5);

        do_write(8'($urandom));
        @(negedge clk);
        f.fiford = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (f.rd === 1'b0) found = 1'b1;
        end
        chk("mid_read_seen", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_rd", 32'(f.rd), 32'd1);
        chk_flags("mid_rst");
        f.fiford = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        do_read();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_fifo_subsystem.md
SRAM_FIFO_SUBSYSTEM -- requirements
Module: sram_fifo

Parameters
REQ-001 The block SHALL have parameter FIFO_SIZE, default 8, giving the FIFO depth in words (1..2048).
REQ-002 The block SHALL have parameter DW, default 8, giving the data width.
REQ-003 The block SHALL have parameter AW, default 11, giving the SRAM address width.

Interface
REQ-004 Port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port in_data, input, DW bits: write data, stable while fifowr is low.
REQ-007 Port fifowr, input, 1 bit: active-low write strobe, asynchronous to clk, low for at least 4 clk periods.
REQ-008 Port fiford, input, 1 bit: active-low read strobe, with the same timing as fifowr.
REQ-009 Port out_data, output, DW bits: registered read data.
REQ-010 Port nfull, output, 1 bit: low when the FIFO holds FIFO_SIZE words.
REQ-011 Port nempty, output, 1 bit: low when the FIFO holds 0 words.
REQ-012 Port address, output, AW bits: current SRAM address, for observation.
REQ-013 Port rd, output, 1 bit: SRAM output enable, active-low, for observation.
REQ-014 Port wr, output, 1 bit: SRAM write enable, active-low, for observation.

Function
REQ-015 The block SHALL contain a controller and a 2^AW x DW asynchronous SRAM.
- The two SHALL be joined by a bidirectional data bus; the SRAM chip select SHALL be tied active (low).
REQ-016 SRAM behaviour:
- When SRW is low, it SHALL store the bus value at the address.
- When its output enable is low and SRW is high, it SHALL drive mem[address] onto the bus.
- Otherwise it SHALL leave the bus at high-Z.
REQ-017 The controller SHALL register fifowr and fiford on clk.
- A request SHALL occur on the first clk edge where the registered strobe is low and its previous registered value was high.
- A single strobe SHALL cause exactly one access.
REQ-018 The controller SHALL hold a write pointer, a read pointer, both 0..FIFO_SIZE-1 and wrapping to 0 after FIFO_SIZE-1, and a count 0..FIFO_SIZE.
REQ-019 The FSM SHALL have states IDLE, WRITE and READ, with these transitions:
- IDLE->WRITE on a write request with count<FIFO_SIZE.
- IDLE->READ on a read request with count>0.
- WRITE->IDLE and READ->IDLE after one cycle.
REQ-020 In WRITE:
- address=write pointer.
- The controller SHALL drive in_data onto the bus.
- wr=0 for exactly one cycle.
- At the end of the cycle: write pointer+1, count+1.
REQ-021 In READ:
- address=read pointer.
- rd=0.
- At the end of the cycle: out_data captures the bus, read pointer+1, count-1.
REQ-022 When neither WRITE nor READ is active:
- The controller SHALL release the bus.
- wr and rd SHALL be 1.
- address SHALL hold its last value.
REQ-023 Latency: out_data SHALL be valid no later than 3 clk edges after fiford falls, i.e. before a 4-cycle strobe is released.
REQ-024 Write when full (count=FIFO_SIZE): the request SHALL be discarded; memory, pointers and count SHALL be unchanged.
REQ-025 Read when empty: the request SHALL be discarded; out_data, pointers and count SHALL be unchanged.
REQ-026 Simultaneous requests on the same edge: the write SHALL be serviced first, and the read SHALL be serviced on the following cycle.
- The read's empty check SHALL use the count evaluated after the write.
REQ-027 Flags SHALL be registered: nfull=(count!=FIFO_SIZE) and nempty=(count!=0), updated in the cycle after the count changes.

Reset
REQ-028 On rst=0, asynchronously and at any time including mid-access, the block SHALL take these values:
- Pointers and count =0.
- State=IDLE.
- out_data=0, address=0.
- rd=1, wr=1, bus released.
- nempty=0, nfull=1.
- Edge-detect registers =1.
REQ-029 SRAM contents SHALL NOT be cleared by reset; data written before reset SHALL be unreachable afterwards.

Verification
REQ-030 Write 8 random words with FIFO_SIZE=8. Required: nempty rises after the first write, nfull=0 after the 8th, and 2 further writes change nothing.
REQ-031 Read 8 words from the full FIFO. Required: data returns in write order, nfull=1 after the first read, and nempty=0 after the 8th.
REQ-032 Issue 2 reads on the empty FIFO. Required: out_data holds the last value and the flags are unchanged.
REQ-033 Run 16 alternating write/read pairs from empty (pointers wrap twice). Required: each read returns the word just written, and nempty=0 after each pair.
REQ-034 Write 3 words, reset, then read once. Required: empty read discarded; then write 0xA5 and read once, required 0xA5.
REQ-035 Assert rst low during a READ cycle. Required: rd=1 and out_data=0 immediately, and the flags read empty.
